// File: rtl/vend_pkg.sv
// vend_pkg: coin codes, FSM states and change-output width shared by the vending controller.
package vend_pkg;
  localparam logic [1:0] COIN_NONE = 2'd0, COIN_HALF = 2'd1, COIN_ONE = 2'd2, COIN_CANCEL = 2'd3;
  localparam int BACK_W = 2;
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
endpackage

// File: rtl/vend_stock_bank.sv
// vend_stock_bank: per-item stock counters with vend decrement and restock (restock wins on a tie).
module vend_stock_bank #(
  parameter int N_ITEMS = 4,
  parameter int SEL_W = 2,
  parameter int STOCK_MAX = 3,
  parameter int STOCK_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec,
  input  logic [SEL_W-1:0]   dec_id,
  input  logic               restock,
  input  logic [SEL_W-1:0]   restock_id,
  output logic [N_ITEMS-1:0] sold_out,
  output logic [N_ITEMS-1:0] nz
);
  for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
    logic [STOCK_W-1:0] stock;
    always_ff @(posedge clk or negedge reset)
      if (!reset) stock <= STOCK_W'(STOCK_MAX);
      else if (restock && restock_id == SEL_W'(i)) stock <= STOCK_W'(STOCK_MAX);
      else if (dec && dec_id == SEL_W'(i)) stock <= stock - 1'b1;
    assign nz[i] = stock != '0;
    assign sold_out[i] = ~nz[i];
  end
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: multi-item vending FSM with saturating credit, stock checks and multi-cycle change payout.
module vend_ctrl import vend_pkg::*; #(
  parameter int N_ITEMS = 4,
  parameter int SEL_W = 2,
  parameter int PRICE_W = 4,
  parameter int CREDIT_W = 4,
  parameter int MAX_CREDIT = 15,
  parameter int STOCK_MAX = 3,
  parameter int STOCK_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 coin,
  input  logic                       sel_valid,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       restock,
  input  logic [SEL_W-1:0]           restock_id,
  input  logic [N_ITEMS*PRICE_W-1:0] prices,
  output logic                       drink,
  output logic [SEL_W-1:0]           drink_id,
  output logic [BACK_W-1:0]          back,
  output logic                       coin_reject,
  output logic                       busy,
  output logic [CREDIT_W-1:0]        credit,
  output logic [N_ITEMS-1:0]         sold_out
);
  localparam int EW = CREDIT_W + 1;
  typedef logic [EW-1:0] ext_t;
  state_t state;
  logic [N_ITEMS-1:0] nz;
  logic [PRICE_W-1:0] price;
  logic [BACK_W-1:0] pay;
  ext_t sum, eff, pr;
  logic idle, coin_val, accept, cancel, ok, pay_go;
  assign idle = state == IDLE || state == CREDIT;
  assign coin_val = coin == COIN_HALF || coin == COIN_ONE;
  assign sum = ext_t'(credit) + ext_t'(coin_val ? coin : COIN_NONE);
  assign accept = coin_val && sum <= ext_t'(MAX_CREDIT);
  assign eff = accept ? sum : ext_t'(credit);
  assign price = prices[int'(sel)*PRICE_W +: PRICE_W];
  assign pr = ext_t'(price);
  assign cancel = state == CREDIT && coin == COIN_CANCEL;
  assign ok = idle && !cancel && sel_valid && int'(sel) < N_ITEMS && price != '0 && nz[sel] && eff >= pr;
  // Leaving VEND or continuing CHANGE with credit left pays the next chunk on this edge
  assign pay_go = cancel || (!idle && credit != '0);
  assign pay = credit > CREDIT_W'(1) ? BACK_W'(2) : BACK_W'(credit);
  vend_stock_bank #(
    .N_ITEMS(N_ITEMS), .SEL_W(SEL_W), .STOCK_MAX(STOCK_MAX), .STOCK_W(STOCK_W)
  ) u_stock (
    .clk(clk), .reset(reset), .dec(ok), .dec_id(sel),
    .restock(restock), .restock_id(restock_id), .sold_out(sold_out), .nz(nz)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      credit <= '0;
      drink <= 1'b0;
      drink_id <= '0;
      back <= '0;
      coin_reject <= 1'b0;
      busy <= 1'b0;
    end else begin
      drink <= ok;
      coin_reject <= coin_val && (!idle || !accept);
      busy <= ok || pay_go;
      back <= '0;
      if (ok) begin
        drink_id <= sel;
        credit <= CREDIT_W'(eff - pr);
        state <= VEND;
      end else if (pay_go) begin
        back <= pay;
        credit <= credit - CREDIT_W'(pay);
        state <= CHANGE;
      end else if (idle) begin
        credit <= CREDIT_W'(eff);
        state <= eff != '0 ? CREDIT : IDLE;
      end else state <= IDLE;
    end
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed self-checking bench for vend_ctrl with prices {4,2,5,3}.
module tb_vend_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] coin = 2'd0;
  logic sel_valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic restock = 1'b0;
  logic [1:0] restock_id = 2'd0;
  logic [15:0] prices = 16'h4253;
  logic drink, coin_reject, busy;
  logic [1:0] drink_id, back;
  logic [3:0] credit, sold_out;
  int errors = 0;
  int checks = 0;
  int total;

  vend_ctrl dut (
    .clk(clk), .reset(reset), .coin(coin), .sel_valid(sel_valid), .sel(sel),
    .restock(restock), .restock_id(restock_id), .prices(prices),
    .drink(drink), .drink_id(drink_id), .back(back), .coin_reject(coin_reject),
    .busy(busy), .credit(credit), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] c, input logic sv, input logic [1:0] s);
    coin = c;
    sel_valid = sv;
    sel = s;
    @(posedge clk);
    #1;
    coin = 2'd0;
    sel_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_drink", drink, 0);
    chk("rst_drink_id", drink_id, 0);
    chk("rst_back", back, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_busy", busy, 0);
    chk("rst_credit", credit, 0);
    chk("rst_sold_out", sold_out, 0);
    reset = 1'b1;
    // coins 1 then 2, buy item0 (price 3)
    step(2'd1, 0, 0);
    chk("s1_credit1", credit, 1);
    step(2'd2, 0, 0);
    chk("s1_credit3", credit, 3);
    step(2'd0, 1, 0);
    chk("s1_drink", drink, 1);
    chk("s1_drink_id", drink_id, 0);
    chk("s1_credit0", credit, 0);
    chk("s1_busy", busy, 1);
    step(2'd0, 0, 0);
    chk("s1_drink_off", drink, 0);
    chk("s1_no_back", back, 0);
    chk("s1_idle", busy, 0);
    // coins 2,2,2 then item0: change 3 = 2 + 1
    repeat (3) step(2'd2, 0, 0);
    chk("s2_credit6", credit, 6);
    step(2'd0, 1, 0);
    chk("s2_drink", drink, 1);
    chk("s2_credit3", credit, 3);
    chk("s2_vend_back0", back, 0);
    step(2'd0, 0, 0);
    chk("s2_back2", back, 2);
    chk("s2_busy", busy, 1);
    step(2'd0, 0, 0);
    chk("s2_back1", back, 1);
    chk("s2_credit0", credit, 0);
    step(2'd0, 0, 0);
    chk("s2_back_end", back, 0);
    chk("s2_idle", busy, 0);
    // coins 2,1,1 then cancel
    step(2'd2, 0, 0);
    step(2'd1, 0, 0);
    step(2'd1, 0, 0);
    chk("s3_credit4", credit, 4);
    step(2'd3, 1, 2);
    chk("s3_back2a", back, 2);
    chk("s3_no_drink", drink, 0);
    step(2'd0, 0, 0);
    chk("s3_back2b", back, 2);
    chk("s3_credit0", credit, 0);
    step(2'd0, 0, 0);
    chk("s3_back_end", back, 0);
    chk("s3_idle", busy, 0);
    // saturation at 15
    repeat (7) step(2'd2, 0, 0);
    chk("s4_credit14", credit, 14);
    step(2'd2, 0, 0);
    chk("s4_reject", coin_reject, 1);
    chk("s4_credit_held", credit, 14);
    step(2'd1, 0, 0);
    chk("s4_reject_off", coin_reject, 0);
    chk("s4_credit15", credit, 15);
    step(2'd3, 0, 0);
    chk("s4_cancel_back", back, 2);
    total = back;
    step(2'd1, 0, 0);
    chk("s4_busy_reject", coin_reject, 1);
    chk("s4_credit11", credit, 11);
    total += back;
    for (int i = 0; i < 20 && busy; i++) begin
      step(2'd0, 0, 0);
      total += back;
    end
    chk("s4_drained", busy, 0);
    chk("s4_total_back", total, 15);
    chk("s4_credit0", credit, 0);
    // coin and select in the same cycle: 1 + 2 covers item0 price 3, last item0
    step(2'd1, 0, 0);
    step(2'd2, 1, 0);
    chk("s5_eff_drink", drink, 1);
    chk("s5_eff_credit", credit, 0);
    chk("s5_item0_out", sold_out, 4'b0001);
    step(2'd0, 0, 0);
    // item2 (price 2) three times
    repeat (3) begin
      step(2'd2, 0, 0);
      step(2'd0, 1, 2);
      chk("s6_drink", drink, 1);
      chk("s6_drink_id", drink_id, 2);
      step(2'd0, 0, 0);
    end
    chk("s6_sold_out", sold_out, 4'b0101);
    step(2'd2, 0, 0);
    step(2'd0, 1, 2);
    chk("s6_empty_no_drink", drink, 0);
    chk("s6_empty_credit", credit, 2);
    restock = 1'b1;
    restock_id = 2'd2;
    step(2'd0, 0, 0);
    restock = 1'b0;
    chk("s6_restocked", sold_out, 4'b0001);
    step(2'd0, 1, 2);
    chk("s6_after_restock", drink, 1);
    chk("s6_credit0", credit, 0);
    step(2'd0, 0, 0);
    // credit 6, item1 (price 5), reset during change
    repeat (3) step(2'd2, 0, 0);
    step(2'd0, 1, 1);
    chk("s7_drink", drink, 1);
    chk("s7_drink_id", drink_id, 1);
    chk("s7_credit1", credit, 1);
    step(2'd0, 0, 0);
    chk("s7_back1", back, 1);
    reset = 1'b0;
    #1;
    chk("s7_rst_back", back, 0);
    chk("s7_rst_busy", busy, 0);
    chk("s7_rst_credit", credit, 0);
    chk("s7_rst_drink_id", drink_id, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(2'd0, 0, 0);
    chk("s7_post_back", back, 0);
    chk("s7_post_busy", busy, 0);
    chk("s7_post_stock", sold_out, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
